ctrl_fifo_wr: RTL and testbench



---
 rtl/ctrl_fifo_pkg.sv | 31 +++
 rtl/ctrl_fifo_wr.sv | 144 ++++++++++++++
 tb/tb_ctrl_fifo_wr.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_fifo_pkg.sv
// Shared types for the 80-bit command FIFO: writer FSM states and the packed
// command entry layout also used by the FIFO reader.
package ctrl_fifo_pkg;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 32;
    localparam int WAIT_LSB = 32;
    localparam int WAIT_W   = 32;
    localparam int CTRL_LSB = 64;
    localparam int CTRL_W   = 8;
    localparam int QSEL_LSB = 72;
    localparam int QSEL_W   = 8;
    localparam int CMD_W    = 80;

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_WAIT,
        ST_CTRL,
        ST_WRITE,
        ST_DRAIN
    } state_e;

    // wait is a keyword, so the delay field is wait_cyc
    typedef struct packed {
        logic [QSEL_W-1:0] qsel;
        logic [CTRL_W-1:0] ctrl;
        logic [WAIT_W-1:0] wait_cyc;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

endpackage

// File: rtl/ctrl_fifo_wr.sv
// Command FIFO writer: packs 3-beat AXI-Stream packets into one 80-bit entry.
// Optional WAIT_CLAMP_EN raises latched wait values below MIN_WAIT to MIN_WAIT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_ADDR  | waiting for beat 1 (addr); tlast here is a framing error
// ST_WAIT  | waiting for beat 2 (wait); tlast here is a framing error
// ST_CTRL  | waiting for beat 3 (ctrl/qsel); must carry tlast
// ST_WRITE | entry complete, writing to FIFO as soon as it is not full
// ST_DRAIN | bad packet, discarding beats up to and including tlast
module ctrl_fifo_wr
    import ctrl_fifo_pkg::*;
#(
    parameter int MIN_WAIT = 3,
    parameter int BC       = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          clr,
    input  logic [31:0]   s_axis_tdata,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic          fifo_wr_en,
    input  logic          fifo_full,
    output logic [79:0]   fifo_din,
    output logic          err_o,
    output logic [BC-1:0] cmd_cnt
);

    state_e          state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic            err_q, err_d;
    logic [BC-1:0]   cnt_q, cnt_d;
    logic            beat;
    logic            frame_err;
    logic            wr;
    logic [31:0]     wait_in;

    if (MIN_WAIT < 0 || BC < 1) begin : g_param_chk
        $error("ctrl_fifo_wr: MIN_WAIT must be >= 0 and BC >= 1");
    end

`ifdef WAIT_CLAMP_EN
    localparam logic [31:0] MIN_WAIT_W = 32'(MIN_WAIT);
    assign wait_in = (s_axis_tdata < MIN_WAIT_W) ? MIN_WAIT_W : s_axis_tdata;
`else
    assign wait_in = s_axis_tdata;
`endif

    // Handshake outputs are forced low while reset is asserted so a pending
    // entry is never written during reset.
    always_comb begin
        s_axis_tready = 1'b0;
        if (rstn && en) begin
            s_axis_tready = (state_q inside {ST_ADDR, ST_WAIT, ST_CTRL, ST_DRAIN});
        end
    end

    assign wr         = rstn & (state_q == ST_WRITE) & ~fifo_full;
    assign fifo_wr_en = wr;
    assign beat       = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        frame_err = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        frame_err = 1'b1;
                    end else begin
                        cmd_d.addr = s_axis_tdata;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        frame_err = 1'b1;
                        state_d   = ST_ADDR;
                    end else begin
                        cmd_d.wait_cyc = wait_in;
                        state_d        = ST_CTRL;
                    end
                end
            end
            ST_CTRL: begin
                if (beat) begin
                    if (s_axis_tlast) begin
                        cmd_d.ctrl = s_axis_tdata[7:0];
                        cmd_d.qsel = s_axis_tdata[15:8];
                        state_d    = ST_WRITE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && s_axis_tlast) begin
                    state_d = ST_ADDR;
                end
            end
            ST_WRITE: begin
                if (wr) begin
                    state_d = ST_ADDR;
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    // A same-cycle event beats clr: error sets, a write counts as 1.
    always_comb begin
        err_d = (err_q & ~clr) | frame_err;
        cnt_d = (clr ? {BC{1'b0}} : cnt_q) + {{(BC-1){1'b0}}, wr};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_ADDR;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_din[ADDR_LSB +: ADDR_W] = cmd_q.addr;
    assign fifo_din[WAIT_LSB +: WAIT_W] = cmd_q.wait_cyc;
    assign fifo_din[CTRL_LSB +: CTRL_W] = cmd_q.ctrl;
    assign fifo_din[QSEL_LSB +: QSEL_W] = cmd_q.qsel;
    assign err_o   = err_q;
    assign cmd_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_fifo_wr.sv
// Self-checking bench for ctrl_fifo_wr: vector table, directed corner cases
// and a random phase against a packet-level reference model.
module tb_ctrl_fifo_wr;
    import ctrl_fifo_pkg::*;

    localparam int BC       = 32;
    localparam int MIN_WAIT = 3;
`ifdef WAIT_CLAMP_EN
    localparam logic [31:0] EXP_W1 = 32'd3;
`else
    localparam logic [31:0] EXP_W1 = 32'd1;
`endif

    logic          clk = 1'b0;
    logic          rstn, en, clr, tvalid, tlast, tready, wr_en, full, err;
    logic [31:0]   tdata;
    logic [79:0]   din;
    logic [BC-1:0] cnt;

    always #5 clk = ~clk;

    ctrl_fifo_wr #(.MIN_WAIT(MIN_WAIT), .BC(BC)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
        .s_axis_tready(tready), .fifo_wr_en(wr_en), .fifo_full(full),
        .fifo_din(din), .err_o(err), .cmd_cnt(cnt)
    );

    int checks   = 0;
    int failures = 0;

    // reference model: beats of the packet in progress, completed entries
    // waiting for the FIFO, error flag and write count
    logic [31:0]   beats[$];
    cmd_t          pend[$];
    logic          m_err = 1'b0;
    logic [BC-1:0] m_cnt = '0;
    bit            m_known = 0;
    logic          s_rdy, s_wr;
    logic [79:0]   s_din;
    int            n_writes = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wm(input logic [31:0] w);
`ifdef WAIT_CLAMP_EN
        return (w < 32'(MIN_WAIT)) ? 32'(MIN_WAIT) : w;
`else
        return w;
`endif
    endfunction

    function automatic cmd_t mk(input logic [31:0] a, input logic [31:0] w, input logic [31:0] c);
        cmd_t r;
        r.addr     = a;
        r.wait_cyc = wm(w);
        r.ctrl     = c[7:0];
        r.qsel     = c[15:8];
        return r;
    endfunction

    task automatic model_cycle();
        logic ex_rdy, ex_wr, ferr;
        int   n;
        s_rdy = tready;
        s_wr  = wr_en;
        s_din = din;
        if (m_known) begin
            chk("err_o", err, m_err);
            chk("cmd_cnt", cnt, m_cnt);
        end
        if (!rstn) begin
            chk("tready_in_reset", tready, 1'b0);
            chk("wr_en_in_reset", wr_en, 1'b0);
            beats.delete();
            pend.delete();
            m_err   = 1'b0;
            m_cnt   = '0;
            m_known = 1;
            return;
        end
        ex_rdy = en && (pend.size() == 0);
        ex_wr  = (pend.size() != 0) && !full;
        chk("tready", tready, ex_rdy);
        chk("fifo_wr_en", wr_en, ex_wr);
        if (ex_wr) begin
            chk("fifo_din", din, pend[0]);
            void'(pend.pop_front());
            n_writes++;
        end
        ferr = 1'b0;
        if (tvalid && ex_rdy) begin
            beats.push_back(tdata);
            n = beats.size();
            if (tlast) begin
                if (n == 3) pend.push_back(mk(beats[0], beats[1], beats[2]));
                else if (n < 3) ferr = 1'b1;
                beats.delete();
            end else if (n == 3) begin
                ferr = 1'b1;
            end
        end
        m_err = (clr ? 1'b0 : m_err) | ferr;
        m_cnt = (clr ? '0 : m_cnt) + (ex_wr ? 1 : 0);
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic v,
                        input logic l, input logic [31:0] d, input logic f);
        rstn = r; en = e; clr = c; tvalid = v; tlast = l; tdata = d; full = f;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        step(1, 1, 0, 1, l, d, 0);
    endtask

    task automatic idle();
        step(1, 1, 0, 0, 0, 32'h0, 0);
    endtask

    typedef struct {
        logic          e, c, v, l, f;
        logic [31:0]   d;
        logic          x_rdy, x_wr;
        logic [79:0]   x_din;
        logic          x_err;
        logic [BC-1:0] x_cnt;
    } vec_t;

    function automatic vec_t mkv(input logic e, c, v, l, f, input logic [31:0] d,
                                 input logic x_rdy, x_wr, input logic [79:0] x_din,
                                 input logic x_err, input logic [BC-1:0] x_cnt);
        vec_t t;
        t.e = e; t.c = c; t.v = v; t.l = l; t.f = f; t.d = d;
        t.x_rdy = x_rdy; t.x_wr = x_wr; t.x_din = x_din; t.x_err = x_err; t.x_cnt = x_cnt;
        return t;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[8];
        logic [31:0] gq_d[$];
        logic        gq_l[$];

        tbl[0] = mkv(1, 0, 1, 0, 0, 32'h0000_1000, 1, 0, '0, 0, 0);
        tbl[1] = mkv(1, 0, 1, 0, 0, 32'h0000_0020, 1, 0, '0, 0, 0);
        tbl[2] = mkv(1, 0, 1, 1, 0, 32'h0000_0301, 1, 0, '0, 0, 0);
        tbl[3] = mkv(1, 0, 0, 0, 0, 32'h0, 0, 1, 80'h03_01_00000020_00001000, 0, 1);
        tbl[4] = mkv(1, 0, 0, 0, 0, 32'h0, 1, 0, '0, 0, 1);
        tbl[5] = mkv(0, 0, 1, 0, 0, 32'h0000_5000, 0, 0, '0, 0, 1);
        tbl[6] = mkv(1, 0, 1, 1, 0, 32'h0000_5000, 1, 0, '0, 1, 1);
        tbl[7] = mkv(1, 1, 0, 0, 0, 32'h0, 1, 0, '0, 0, 0);

        // reset
        step(0, 1, 0, 1, 0, 32'h1234, 0);
        step(0, 1, 0, 1, 0, 32'h1234, 0);
        chk("rst_tready", s_rdy, 1'b0);
        chk("rst_wr_en", s_wr, 1'b0);
        chk("rst_fifo_din", din, 80'h0);
        chk("rst_err_o", err, 1'b0);
        chk("rst_cmd_cnt", cnt, 0);

        // vector table: normal command, en gating, framing error, clr
        for (int i = 0; i < 8; i++) begin
            step(1, tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].l, tbl[i].d, tbl[i].f);
            chk($sformatf("vec%0d_tready", i), s_rdy, tbl[i].x_rdy);
            chk($sformatf("vec%0d_wr_en", i), s_wr, tbl[i].x_wr);
            if (tbl[i].x_wr) chk($sformatf("vec%0d_din", i), s_din, tbl[i].x_din);
            chk($sformatf("vec%0d_err", i), err, tbl[i].x_err);
            chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].x_cnt);
        end

        // backpressure: full for 10 cycles while the next packet waits
        beat(32'h0000_A000, 0); beat(32'h0000_0040, 0); beat(32'h0000_0502, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 1, 0, 32'h0000_B000, 1);
            chk("bp_tready", s_rdy, 1'b0);
            chk("bp_wr_en", s_wr, 1'b0);
        end
        step(1, 1, 0, 1, 0, 32'h0000_B000, 0);
        chk("bp_release_wr", s_wr, 1'b1);
        chk("bp_release_din", s_din, 80'h05_02_00000040_0000A000);
        chk("bp_cnt", cnt, 1);
        beat(32'h0000_B000, 0);
        chk("bp_next_accept", s_rdy, 1'b1);
        beat(32'h0000_0007, 0); beat(32'h0000_0102, 1); idle();
        chk("bp_next_wr", s_wr, 1'b1);
        chk("bp_next_din", s_din, mk(32'hB000, 32'h7, 32'h0102));

        // early tlast
        beat(32'h0000_C000, 0); beat(32'h0000_0009, 1);
        chk("early_err", err, 1'b1);
        idle(); chk("early_no_wr", s_wr, 1'b0);
        beat(32'h0000_D000, 0); beat(32'h0000_0050, 0); beat(32'h0000_0A0B, 1); idle();
        chk("early_next_din", s_din, mk(32'hD000, 32'h50, 32'h0A0B));

        // missing tlast: beats 4-5 drained
        step(1, 1, 1, 0, 0, 32'h0, 0);
        chk("clr_err", err, 1'b0);
        beat(32'h0000_E000, 0); beat(32'h0000_0060, 0); beat(32'h0000_0C0D, 0);
        chk("miss_err", err, 1'b1);
        beat(32'h1111_1111, 0); chk("drain4_rdy", s_rdy, 1'b1);
        beat(32'h2222_2222, 1); chk("drain5_rdy", s_rdy, 1'b1);
        idle(); chk("miss_no_wr", s_wr, 1'b0);
        beat(32'h0000_F000, 0); beat(32'h0000_0070, 0); beat(32'h0000_0E0F, 1); idle();
        chk("miss_next_din", s_din, mk(32'hF000, 32'h70, 32'h0E0F));

        // clr coinciding with write, then with framing error
        beat(32'h0000_1100, 0); beat(32'h0000_0080, 0); beat(32'h0000_0001, 1);
        step(1, 1, 1, 0, 0, 32'h0, 0);
        chk("clr_wr_cnt", cnt, 1);
        step(1, 1, 1, 1, 1, 32'h0000_1200, 0);
        chk("clr_ferr_err", err, 1'b1);

        // en low pauses a partial packet but not a pending write
        beat(32'h0000_1300, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0, 32'h0000_0090, 0);
            chk("en_low_rdy", s_rdy, 1'b0);
        end
        beat(32'h0000_0090, 0); beat(32'h0000_0203, 1);
        step(1, 0, 0, 0, 0, 32'h0, 0);
        chk("en_low_wr", s_wr, 1'b1);
        chk("en_low_din", s_din, mk(32'h1300, 32'h90, 32'h0203));

        // reset mid-packet
        beat(32'h0000_1400, 0); beat(32'h0000_00A0, 0);
        step(0, 1, 0, 0, 0, 32'h0, 0);
        idle(); chk("rst_mid_no_wr", s_wr, 1'b0);
        beat(32'h0000_1500, 0); beat(32'h0000_00B0, 0); beat(32'h0000_0405, 1); idle();
        chk("rst_mid_wr", s_wr, 1'b1);
        chk("rst_mid_din", s_din, mk(32'h1500, 32'hB0, 32'h0405));
        chk("rst_mid_cnt", cnt, 1);

        // wait clamp boundary
        beat(32'h0000_1600, 0); beat(32'h0000_0001, 0); beat(32'h0000_0607, 1); idle();
        chk("wait1", s_din[63:32], EXP_W1);
        beat(32'h0000_1700, 0); beat(32'd100, 0); beat(32'h0000_0809, 1); idle();
        chk("wait100", s_din[63:32], 32'd100);

        // random phase against the model
        n_writes = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic r, e, c, v, f;
            if (gq_d.size() == 0) begin
                int len;
                len = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(1, 5));
                for (int k = 0; k < len; k++) begin
                    gq_d.push_back($urandom);
                    gq_l.push_back(k == len - 1);
                end
            end
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 3) == 0);
            step(r, e, c, v, gq_l[0], gq_d[0], f);
            if (v && s_rdy) begin
                void'(gq_d.pop_front());
                void'(gq_l.pop_front());
            end
        end
        for (int i = 0; i < 6; i++) idle();
        chk("rand_pend_drained", pend.size(), 0);
        chk("rand_activity", (n_writes > 50), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
